// File: rtl/rotating_divider.sv
`default_nettype none
// ============================================================================
// rotating_divider : sequential restoring divider on a rotating operand pair
// Rev 1.0
// ============================================================================
module rotating_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic [1:0]       select,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             error
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [WIDTH-1:0]   sel_dividend;
   logic [WIDTH-1:0]   sel_divisor;
   logic [WIDTH-1:0]   divisor_q;
   logic [WIDTH-1:0]   q_work;
   logic [WIDTH-1:0]   q_step;
   logic [WIDTH:0]     r_work;
   logic [WIDTH:0]     r_shift;
   logic [WIDTH:0]     r_step;
   logic [CNT_W-1:0]   count;
   logic               last_step;
   logic               div_zero;

   always_comb begin
      sel_dividend = A;
      sel_divisor  = B;
      case (select)
         2'b00:   begin sel_dividend = A; sel_divisor = B; end
         2'b01:   begin sel_dividend = B; sel_divisor = C; end
         2'b10:   begin sel_dividend = C; sel_divisor = D; end
         default: begin sel_dividend = D; sel_divisor = A; end
      endcase
   end

   assign div_zero = (sel_divisor == '0);

   // One restoring step: shift the next dividend bit into R, subtract if it fits.
   always_comb begin
      r_shift = {r_work[WIDTH-1:0], q_work[WIDTH-1]};
      q_step  = {q_work[WIDTH-2:0], 1'b0};
      r_step  = r_shift;
      if (r_shift >= {1'b0, divisor_q}) begin
         r_step    = r_shift - {1'b0, divisor_q};
         q_step[0] = 1'b1;
      end
   end

   assign last_step = (count == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = div_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (last_step) begin
               state_nx = S_DONE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         divisor_q <= '0;
         q_work    <= '0;
         r_work    <= '0;
         count     <= '0;
         quotient  <= '0;
         remainder <= '0;
         error     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  divisor_q <= sel_divisor;
                  q_work    <= sel_dividend;
                  r_work    <= '0;
                  count     <= '0;
                  error     <= div_zero;
                  // Divide-by-zero completes immediately with a saturated quotient.
                  if (div_zero) begin
                     quotient  <= '1;
                     remainder <= sel_dividend;
                  end
               end
            end
            S_CALC: begin
               r_work <= r_step;
               q_work <= q_step;
               count  <= count + 1'b1;
               if (last_step) begin
                  quotient  <= q_step;
                  remainder <= r_step[WIDTH-1:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state == S_CALC);
   assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rotating_divider.sv
`default_nettype none
// Directed and randomised checks of rotating_divider at WIDTH=8 and WIDTH=16.
module tb_rotating_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start8, busy8, done8, err8;
   logic [1:0]  sel8;
   logic [7:0]  a8, b8, c8, d8, q8, r8;
   logic        start16, busy16, done16, err16;
   logic [1:0]  sel16;
   logic [15:0] a16, b16, c16, d16, q16, r16;

   int total = 0;
   int bad   = 0;

   rotating_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8),
      .A(a8), .B(b8), .C(c8), .D(d8), .select(sel8),
      .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .error(err8)
   );

   rotating_divider #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16),
      .A(a16), .B(b16), .C(c16), .D(d16), .select(sel16),
      .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .error(err16)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sample(input bit w16, output logic bsy, output logic dn, output logic er,
                         output logic [15:0] q, output logic [15:0] r);
      bsy = w16 ? busy16 : busy8;
      dn  = w16 ? done16 : done8;
      er  = w16 ? err16  : err8;
      q   = w16 ? q16    : {8'd0, q8};
      r   = w16 ? r16    : {8'd0, r8};
   endtask

   // Issue one request and follow it to completion, optionally scrambling inputs meanwhile.
   task automatic run_op(input string tag, input bit w16, input logic [1:0] sel,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic [15:0] eq, input logic [15:0] er_exp,
                         input bit ee, input bit scramble);
      int   edges = 0;
      int   busy_cycles = 0;
      int   width = w16 ? 16 : 8;
      int   exp_edges = ee ? 1 : width + 1;
      bit   overlap = 0;
      logic bsy, dn, e;
      logic [15:0] q, r;
      @(negedge clk);
      if (w16) begin
         a16 = a; b16 = b; c16 = c; d16 = d; sel16 = sel; start16 = 1'b1;
      end else begin
         a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0]; sel8 = sel; start8 = 1'b1;
      end
      @(posedge clk);
      #1;
      start8 = 1'b0; start16 = 1'b0;
      sample(w16, bsy, dn, e, q, r);
      check_value({tag, "_err_at_accept"}, e, ee);
      while (1) begin
         edges++;
         if (bsy) busy_cycles++;
         if (bsy && dn) overlap = 1;
         if (dn || edges >= 40) break;
         if (scramble) begin
            if (w16) begin
               a16 = $urandom; b16 = $urandom; c16 = $urandom; d16 = $urandom;
               sel16 = 2'($urandom); start16 = (edges < width - 1) ? 1'($urandom) : 1'b0;
            end else begin
               a8 = $urandom; b8 = $urandom; c8 = $urandom; d8 = $urandom;
               sel8 = 2'($urandom); start8 = (edges < width - 1) ? 1'($urandom) : 1'b0;
            end
         end
         @(posedge clk);
         #1;
         sample(w16, bsy, dn, e, q, r);
      end
      start8 = 1'b0; start16 = 1'b0;
      check_value({tag, "_done_seen"}, dn, 1);
      check_value({tag, "_latency"}, edges, exp_edges);
      check_value({tag, "_busy_cycles"}, busy_cycles, ee ? 0 : width);
      check_value({tag, "_busy_done_overlap"}, overlap, 0);
      check_value({tag, "_quotient"}, q, eq);
      check_value({tag, "_remainder"}, r, er_exp);
      check_value({tag, "_error"}, e, ee);
      @(posedge clk);
      #1;
      sample(w16, bsy, dn, e, q, r);
      check_value({tag, "_done_single"}, dn, 0);
      check_value({tag, "_busy_after"}, bsy, 0);
      check_value({tag, "_quotient_hold"}, q, eq);
   endtask

   initial begin
      logic [15:0] dvd, dvs, ra, rb, rc, rd;
      logic [1:0]  rs;
      int          dones;

      rst_n = 1'b0;
      start8 = 0; sel8 = 0; a8 = 0; b8 = 0; c8 = 0; d8 = 0;
      start16 = 0; sel16 = 0; a16 = 0; b16 = 0; c16 = 0; d16 = 0;
      repeat (2) @(posedge clk);
      #1;
      check_value("rst_busy8", busy8, 0);
      check_value("rst_done8", done8, 0);
      check_value("rst_q8", q8, 0);
      check_value("rst_r8", r8, 0);
      check_value("rst_err8", err8, 0);
      check_value("rst_q16", q16, 0);
      check_value("rst_busy16", busy16, 0);
      rst_n = 1'b1;

      // 8-bit directed vectors: tag, w16, sel, A, B, C, D, quotient, remainder, error, scramble
      run_op("basic",    0, 2'b00, 100, 7,   0,   0,   14,  2,  0, 0);
      run_op("rot_da",   0, 2'b11, 9,   33,  77,  5,   0,   5,  0, 0);
      run_op("rot_bc",   0, 2'b01, 3,   255, 1,   9,   255, 0,  0, 0);
      run_op("rot_cd",   0, 2'b10, 1,   2,   200, 200, 1,   0,  0, 0);
      run_op("divzero",  0, 2'b00, 42,  0,   6,   6,   255, 42, 1, 0);
      run_op("errclear", 0, 2'b00, 100, 7,   0,   0,   14,  2,  0, 0);
      run_op("isolate",  0, 2'b00, 100, 7,   50,  3,   14,  2,  0, 1);

      // start held high on divide-by-zero: done every other cycle
      @(negedge clk);
      a8 = 42; b8 = 0; sel8 = 2'b00; start8 = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done8) dones++;
      end
      start8 = 1'b0;
      check_value("held_start_dones", dones, 4);
      check_value("held_start_q", q8, 255);
      repeat (2) @(posedge clk);

      // reset at CALC step 4
      @(negedge clk);
      a8 = 100; b8 = 7; sel8 = 2'b00; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_value("pre_rst_busy", busy8, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_value("midrst_busy", busy8, 0);
      check_value("midrst_done", done8, 0);
      check_value("midrst_q", q8, 0);
      check_value("midrst_r", r8, 0);
      check_value("midrst_err", err8, 0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done8 || busy8) dones++;
      end
      check_value("midrst_no_activity", dones, 0);
      run_op("post_rst", 0, 2'b01, 0, 200, 9, 0, 22, 2, 0, 0);

      // 16-bit instance
      run_op("w16_basic", 1, 2'b00, 65535, 255, 0, 0, 257, 0, 0, 0);
      run_op("w16_zero",  1, 2'b10, 1, 2, 1234, 0, 16'hFFFF, 1234, 1, 0);
      for (int n = 0; n < 1000; n++) begin
         rs = 2'($urandom);
         ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
         if (n % 50 == 0) rb = 0;
         if (n % 7 == 0) rc = 16'($urandom_range(1, 300));
         case (rs)
            2'b00:   begin dvd = ra; dvs = rb; end
            2'b01:   begin dvd = rb; dvs = rc; end
            2'b10:   begin dvd = rc; dvs = rd; end
            default: begin dvd = rd; dvs = ra; end
         endcase
         if (dvs == 0) run_op("sweep", 1, rs, ra, rb, rc, rd, 16'hFFFF, dvd, 1, 0);
         else          run_op("sweep", 1, rs, ra, rb, rc, rd, dvd / dvs, dvd % dvs, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
